// File: rtl/keypad_entry_if.sv
// Keypad-to-entry-logic signal bundle: scanner drives onehot/unlock, the controller drives the rest.
// The controller uses the slave modport; the scanner/consumer side uses master.
interface keypad_entry_if #(
    parameter int DIGITS  = 4,
    parameter int TRIES_W = 3
);
    logic [15:0]         onehot;
    logic                unlock;
    logic                key_valid;
    logic [3:0]          key_code;
    logic [4*DIGITS-1:0] digits;
    logic [3:0]          digit_count;
    logic                entry_valid;
    logic [4*DIGITS-1:0] entry_value;
    logic [TRIES_W-1:0]  tries;
    logic                locked;

    modport master (
        output onehot, unlock,
        input  key_valid, key_code, digits, digit_count,
               entry_valid, entry_value, tries, locked
    );

    modport slave (
        input  onehot, unlock,
        output key_valid, key_code, digits, digit_count,
               entry_valid, entry_value, tries, locked
    );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Debounces a one-hot keypad vector into key events, builds a BCD entry and locks after MAX_TRIES entries.
// key_valid follows DEBOUNCE_CYCLES+1 cycles after a stable press; no backpressure, inputs sampled every cycle.
module keypad_entry_ctrl #(
    parameter int DIGITS          = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_TRIES       = 5,
    parameter int TRIES_W         = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    keypad_entry_if.slave  kif
);
    localparam int BUF_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [3:0] CODE_ENTER = 4'hA;
    localparam logic [3:0] CODE_CLEAR = 4'hB;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

    state_t             state_q, state_d;
    logic [15:0]        cand_q, cand_d;
    logic [3:0]         cand_code_q, cand_code_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;

    logic               key_valid_q, key_valid_d;
    logic [3:0]         key_code_q, key_code_d;
    logic [BUF_W-1:0]   digits_q, digits_d;
    logic [3:0]         digit_count_q, digit_count_d;
    logic               entry_valid_q, entry_valid_d;
    logic [BUF_W-1:0]   entry_value_q, entry_value_d;
    logic [TRIES_W-1:0] tries_q, tries_d;
    logic               locked_q, locked_d;

    logic [4:0]         in_map;
    logic               buf_full;
    logic [TRIES_W-1:0] tries_inc;

    // Exact-value match also rejects multi-bit vectors; bit 4 flags a mapped key.
    function automatic logic [4:0] map_key(input logic [15:0] v);
        logic [4:0] r;
        case (v)
            16'h0008: r = {1'b1, 4'd0};
            16'h0080: r = {1'b1, 4'd1};
            16'h0040: r = {1'b1, 4'd2};
            16'h0020: r = {1'b1, 4'd3};
            16'h0800: r = {1'b1, 4'd4};
            16'h0400: r = {1'b1, 4'd5};
            16'h0200: r = {1'b1, 4'd6};
            16'h8000: r = {1'b1, 4'd7};
            16'h4000: r = {1'b1, 4'd8};
            16'h2000: r = {1'b1, 4'd9};
            16'h0002: r = {1'b1, CODE_ENTER};
            16'h0001: r = {1'b1, CODE_CLEAR};
            default:  r = 5'd0;
        endcase
        return r;
    endfunction

    assign in_map    = map_key(kif.onehot);
    assign buf_full  = (digit_count_q == 4'(DIGITS));
    assign tries_inc = tries_q + TRIES_W'(1);

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cand_code_d = cand_code_q;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_map[4]) begin
                    cand_d      = kif.onehot;
                    cand_code_d = in_map[3:0];
                    cnt_d       = '0;
                    state_d     = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (kif.onehot != cand_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    accept  = 1'b1;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                // Any nonzero value, including a different key, restarts the release count.
                if (kif.onehot != 16'h0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        key_valid_d   = accept;
        key_code_d    = accept ? cand_code_q : key_code_q;
        digits_d      = digits_q;
        digit_count_d = digit_count_q;
        entry_valid_d = 1'b0;
        entry_value_d = entry_value_q;
        tries_d       = tries_q;
        locked_d      = locked_q;
        if (accept) begin
            if (cand_code_q <= 4'd9) begin
                if (!locked_q && !buf_full) begin
                    digits_d      = (digits_q << 4) | BUF_W'(cand_code_q);
                    digit_count_d = digit_count_q + 4'd1;
                end
            end else if (cand_code_q == CODE_CLEAR) begin
                digits_d      = '0;
                digit_count_d = 4'd0;
            end else if (buf_full && !locked_q && !kif.unlock) begin
                entry_valid_d = 1'b1;
                entry_value_d = digits_q;
                digits_d      = '0;
                digit_count_d = 4'd0;
                tries_d       = tries_inc;
                locked_d      = (tries_inc == TRIES_W'(MAX_TRIES));
            end
        end
        // unlock overrides a simultaneous entry: the entry above was already suppressed.
        if (kif.unlock) begin
            tries_d  = '0;
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cand_q        <= '0;
            cand_code_q   <= '0;
            cnt_q         <= '0;
            key_valid_q   <= 1'b0;
            key_code_q    <= '0;
            digits_q      <= '0;
            digit_count_q <= '0;
            entry_valid_q <= 1'b0;
            entry_value_q <= '0;
            tries_q       <= '0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cand_q        <= cand_d;
            cand_code_q   <= cand_code_d;
            cnt_q         <= cnt_d;
            key_valid_q   <= key_valid_d;
            key_code_q    <= key_code_d;
            digits_q      <= digits_d;
            digit_count_q <= digit_count_d;
            entry_valid_q <= entry_valid_d;
            entry_value_q <= entry_value_d;
            tries_q       <= tries_d;
            locked_q      <= locked_d;
        end
    end

    assign kif.key_valid   = key_valid_q;
    assign kif.key_code    = key_code_q;
    assign kif.digits      = digits_q;
    assign kif.digit_count = digit_count_q;
    assign kif.entry_valid = entry_valid_q;
    assign kif.entry_value = entry_value_q;
    assign kif.tries       = tries_q;
    assign kif.locked      = locked_q;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed and random presses feed a queue-based entry model; a monitor checks each key event.
module tb_keypad_entry_ctrl;
    localparam int DIGITS = 4;
    localparam int DEB    = 4;
    localparam int MAXT   = 3;
    localparam int TW     = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypad_entry_if #(.DIGITS(DIGITS), .TRIES_W(TW)) kif ();

    keypad_entry_ctrl #(
        .DIGITS(DIGITS), .DEBOUNCE_CYCLES(DEB), .MAX_TRIES(MAXT), .TRIES_W(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .kif(kif)
    );

    typedef struct {
        int          code;
        int          cyc;
        bit          entry;
        logic [15:0] ev;
        logic [15:0] dg;
        int          cnt;
        int          tries;
        bit          locked;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    int digit_bit [10] = '{3, 7, 6, 5, 11, 10, 9, 15, 14, 13};

    // Reference model: digits held as a queue of ints, newest at the back.
    int          mq[$];
    int          m_tries = 0;
    logic [15:0] m_ev    = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int key_of(input logic [15:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < 10; i++) if (v[digit_bit[i]]) return i;
        if (v[1]) return 10;
        if (v[0]) return 11;
        return -1;
    endfunction

    function automatic logic [15:0] pack_digits();
        logic [15:0] r = '0;
        foreach (mq[i]) r = (r << 4) | 16'(mq[i]);
        return r;
    endfunction

    task automatic model_key(input int code, input int exp_cyc, input bit unl);
        exp_t e;
        bit   lk = (m_tries == MAXT);
        e.code  = code;
        e.cyc   = exp_cyc;
        e.entry = 1'b0;
        if (code < 10) begin
            if (!lk && mq.size() < DIGITS) mq.push_back(code);
        end else if (code == 11) begin
            mq.delete();
        end else if (mq.size() == DIGITS && !lk && !unl) begin
            e.entry = 1'b1;
            m_ev    = pack_digits();
            mq.delete();
            m_tries++;
        end
        if (unl) m_tries = 0;
        e.ev     = m_ev;
        e.dg     = pack_digits();
        e.cnt    = mq.size();
        e.tries  = m_tries;
        e.locked = (m_tries == MAXT);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (kif.key_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_key_valid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("key_code",    32'(kif.key_code),    32'(e.code));
                    chk("key_cycle",   32'(cyc),             32'(e.cyc));
                    chk("entry_valid", 32'(kif.entry_valid), 32'(e.entry));
                    chk("entry_value", 32'(kif.entry_value), 32'(e.ev));
                    chk("digits",      32'(kif.digits),      32'(e.dg));
                    chk("digit_count", 32'(kif.digit_count), 32'(e.cnt));
                    chk("tries",       32'(kif.tries),       32'(e.tries));
                    chk("locked",      32'(kif.locked),      32'(e.locked));
                end
            end else if (kif.entry_valid) begin
                chk("entry_without_key", 32'd1, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [15:0] v, input int len, input int gap);
        int code = key_of(v);
        if (code >= 0 && len >= DEB + 1) model_key(code, cyc + DEB + 1, 1'b0);
        kif.onehot = v;
        repeat (len) tick();
        kif.onehot = '0;
        repeat ((gap < DEB) ? DEB : gap) tick();
    endtask

    task automatic digit(input int d);
        logic [15:0] v = 16'h1 << digit_bit[d];
        press(v, 6, DEB);
    endtask

    task automatic entry4(input int a, input int b, input int c, input int d);
        digit(a); digit(b); digit(c); digit(d);
        press(16'h0002, 6, DEB);
    endtask

    task automatic pulse_unlock();
        kif.unlock = 1'b1;
        tick();
        kif.unlock = 1'b0;
        m_tries = 0;
        chk("unlock_tries",  32'(kif.tries),  32'd0);
        chk("unlock_locked", 32'(kif.locked), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_key_valid"},   32'(kif.key_valid),   32'd0);
        chk({tag, "_key_code"},    32'(kif.key_code),    32'd0);
        chk({tag, "_digits"},      32'(kif.digits),      32'd0);
        chk({tag, "_digit_count"}, 32'(kif.digit_count), 32'd0);
        chk({tag, "_entry_value"}, 32'(kif.entry_value), 32'd0);
        chk({tag, "_tries"},       32'(kif.tries),       32'd0);
        chk({tag, "_locked"},      32'(kif.locked),      32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          start;
        int          r;
        int          a, b;
        logic [15:0] v;
        int          unmapped [4] = '{2, 4, 8, 12};

        kif.onehot = '0;
        kif.unlock = 1'b0;
        rst_n      = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Short press rejected, long press gives one key.
        press(16'h0080, 3, DEB);
        press(16'h0080, 20, DEB);
        // Multi-bit and unmapped never produce a key.
        press(16'h00C0, 10, DEB);
        press(16'h0010, 10, DEB);

        entry4(1, 2, 3, 4);
        digit(5); digit(6); digit(7); digit(8); digit(9);
        press(16'h0001, 6, DEB);
        digit(1); digit(2);
        press(16'h0002, 6, DEB);
        press(16'h0001, 6, DEB);

        // Lock after MAX_TRIES entries; locked entry ignored.
        pulse_unlock();
        entry4(1, 1, 1, 1);
        entry4(2, 2, 2, 2);
        entry4(3, 3, 3, 3);
        entry4(4, 4, 4, 4);
        pulse_unlock();

        // unlock landing on the same edge as an accepted ENTER.
        digit(9); digit(8); digit(7); digit(6);
        start = cyc;
        model_key(10, start + DEB + 1, 1'b1);
        kif.onehot = 16'h0002;
        repeat (DEB) tick();
        kif.unlock = 1'b1;
        tick();
        kif.unlock = 1'b0;
        repeat (3) tick();
        kif.onehot = '0;
        repeat (DEB) tick();
        press(16'h0001, 6, DEB);

        // Different key while held, and release bounce, both yield one key.
        start = cyc;
        model_key(3, start + DEB + 1, 1'b0);
        kif.onehot = 16'h0020;
        repeat (7) tick();
        kif.onehot = 16'h0400;
        repeat (5) tick();
        kif.onehot = '0;
        repeat (2) tick();
        kif.onehot = 16'h0020;
        repeat (2) tick();
        kif.onehot = '0;
        repeat (DEB) tick();

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 99);
            if (r < 75) begin
                r = $urandom_range(0, 99);
                if (r < 12)      v = 16'h0002;
                else if (r < 18) v = 16'h0001;
                else             v = 16'h1 << digit_bit[$urandom_range(0, 9)];
            end else if (r < 88) begin
                a = $urandom_range(0, 15);
                b = (a + $urandom_range(1, 15)) % 16;
                v = (16'h1 << a) | (16'h1 << b);
            end else begin
                v = 16'h1 << unmapped[$urandom_range(0, 3)];
            end
            press(v, $urandom_range(1, 12), $urandom_range(DEB, DEB + 3));
            if ($urandom_range(0, 9) == 0) pulse_unlock();
        end

        // Reset mid-debounce with the key still held.
        kif.onehot = 16'h0800;
        repeat (2) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        check_all_zero("midreset");
        mq.delete();
        m_tries = 0;
        m_ev    = '0;
        start   = cyc;
        model_key(4, start + DEB + 1, 1'b0);
        rst_n = 1'b1;
        repeat (8) tick();
        kif.onehot = '0;
        repeat (DEB * 3) tick();

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
